// File: rtl/crc_decoding.sv
// USB-style packet decoder: classifies the PID, captures token/data fields
// and checks CRC5/CRC16 residuals, reporting one result strobe per packet.
module crc_decoding (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        bIn,
  input  logic        bInValid,
  input  logic        pktStart,
  input  logic        pktEnd,
  output logic [3:0]  pid,
  output logic [6:0]  addr,
  output logic [3:0]  endp,
  output logic [63:0] data,
  output logic [1:0]  pktType,
  output logic        pktDone,
  output logic        pktOk,
  output logic        errPid,
  output logic        errLen,
  output logic        errCrc,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PID, BODY, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  pid_sr_reg, pid_sr_next;
  logic [2:0]  pid_cnt_reg, pid_cnt_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic [6:0]  exp_reg, exp_next;
  logic [1:0]  type_reg, type_next;
  logic [4:0]  crc5_reg, crc5_next;
  logic [15:0] crc16_reg, crc16_next;
  logic        err_pid_reg, err_pid_next;
  logic        err_len_reg, err_len_next;
  logic [10:0] tok_reg, tok_next;
  logic [63:0] data_reg, data_next;
  logic [7:0]  pid_byte;
  logic        pid_known;
  logic        load_out;
  logic        len_final, crc_bad, crc_final;

  always_comb begin
    state_next   = state_reg;
    pid_sr_next  = pid_sr_reg;
    pid_cnt_next = pid_cnt_reg;
    cnt_next     = cnt_reg;
    exp_next     = exp_reg;
    type_next    = type_reg;
    crc5_next    = crc5_reg;
    crc16_next   = crc16_reg;
    err_pid_next = err_pid_reg;
    err_len_next = err_len_reg;
    tok_next     = tok_reg;
    data_next    = data_reg;
    pid_byte     = {bIn, pid_sr_reg[7:1]};
    pid_known    = 1'b0;

    if (pktStart) begin
      state_next   = PID;
      pid_cnt_next = 3'd0;
      cnt_next     = 7'd0;
      exp_next     = 7'd0;
      type_next    = 2'b11;
      crc5_next    = 5'b11111;
      crc16_next   = 16'hFFFF;
      err_pid_next = 1'b0;
      err_len_next = 1'b0;
      tok_next     = '0;
      data_next    = '0;
    end else begin
      case (state_reg)
        PID: begin
          if (bInValid) begin
            pid_sr_next  = pid_byte;
            pid_cnt_next = pid_cnt_reg + 3'd1;
            if (pid_cnt_reg == 3'd7) begin
              case (pid_byte[3:0])
                4'b0001, 4'b1001, 4'b1101: begin pid_known = 1'b1; type_next = 2'b01; exp_next = 7'd16; end
                4'b0011, 4'b1011:          begin pid_known = 1'b1; type_next = 2'b10; exp_next = 7'd80; end
                4'b0010, 4'b1010, 4'b1110: begin pid_known = 1'b1; type_next = 2'b00; exp_next = 7'd0;  end
                default:                   pid_known = 1'b0;
              endcase
              if (!pid_known || (pid_byte[3:0] != ~pid_byte[7:4])) begin
                err_pid_next = 1'b1;
                type_next    = 2'b11;
                exp_next     = 7'd0;
                state_next   = DRAIN;
              end else begin
                state_next = BODY;
              end
            end
          end
          // A PID completed by the same-cycle bit is not a truncated PID
          if (pktEnd) begin
            state_next = DONE;
            if (!(bInValid && pid_cnt_reg == 3'd7))
              err_len_next = 1'b1;
          end
        end
        BODY: begin
          if (bInValid) begin
            if (cnt_reg < exp_reg) begin
              if (type_reg == 2'b01) begin
                crc5_next = {crc5_reg[3:0], 1'b0} ^ ({5{crc5_reg[4] ^ bIn}} & 5'b00101);
                if (cnt_reg < 7'd11)
                  tok_next[cnt_reg[3:0]] = bIn;
              end else begin
                crc16_next = {crc16_reg[14:0], 1'b0} ^ ({16{crc16_reg[15] ^ bIn}} & 16'h8005);
                if (cnt_reg < 7'd64)
                  data_next[cnt_reg[5:0]] = bIn;
              end
            end else begin
              err_len_next = 1'b1;
            end
            if (cnt_reg != 7'd127)
              cnt_next = cnt_reg + 7'd1;
          end
          if (pktEnd)
            state_next = DONE;
        end
        DRAIN: if (pktEnd) state_next = DONE;
        DONE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    // Result is resolved on the pktEnd edge so it is valid alongside pktDone
    load_out  = (state_next == DONE);
    len_final = err_len_next | (cnt_next != exp_next);
    case (type_next)
      2'b01:   crc_bad = (crc5_next != 5'b01100);
      2'b10:   crc_bad = (crc16_next != 16'h800D);
      default: crc_bad = 1'b0;
    endcase
    crc_final = crc_bad & ~err_pid_next & ~len_final;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg   <= IDLE;
      pid_sr_reg  <= '0;
      pid_cnt_reg <= '0;
      cnt_reg     <= '0;
      exp_reg     <= '0;
      type_reg    <= '0;
      crc5_reg    <= 5'b11111;
      crc16_reg   <= 16'hFFFF;
      err_pid_reg <= 1'b0;
      err_len_reg <= 1'b0;
      tok_reg     <= '0;
      data_reg    <= '0;
      pid         <= '0;
      addr        <= '0;
      endp        <= '0;
      data        <= '0;
      pktType     <= '0;
      pktOk       <= 1'b0;
      errPid      <= 1'b0;
      errLen      <= 1'b0;
      errCrc      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pid_sr_reg  <= pid_sr_next;
      pid_cnt_reg <= pid_cnt_next;
      cnt_reg     <= cnt_next;
      exp_reg     <= exp_next;
      type_reg    <= type_next;
      crc5_reg    <= crc5_next;
      crc16_reg   <= crc16_next;
      err_pid_reg <= err_pid_next;
      err_len_reg <= err_len_next;
      tok_reg     <= tok_next;
      data_reg    <= data_next;
      if (load_out) begin
        pid     <= pid_sr_next[3:0];
        addr    <= tok_next[6:0];
        endp    <= tok_next[10:7];
        data    <= data_next;
        pktType <= type_next;
        errPid  <= err_pid_next;
        errLen  <= len_final;
        errCrc  <= crc_final;
        pktOk   <= ~(err_pid_next | len_final | crc_final);
      end
    end
  end

  assign pktDone = (state_reg == DONE);
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_crc_decoding.sv
// Directed bench for crc_decoding: token, data, handshake, error and reset cases.
module tb_crc_decoding;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        bIn = 1'b0;
  logic        bInValid = 1'b0;
  logic        pktStart = 1'b0;
  logic        pktEnd = 1'b0;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [63:0] data;
  logic [1:0]  pktType;
  logic        pktDone, pktOk, errPid, errLen, errCrc, busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_mark;
  logic [79:0] body, body2;

  crc_decoding dut (
    .clk(clk), .rst_b(rst_b), .bIn(bIn), .bInValid(bInValid),
    .pktStart(pktStart), .pktEnd(pktEnd), .pid(pid), .addr(addr),
    .endp(endp), .data(data), .pktType(pktType), .pktDone(pktDone),
    .pktOk(pktOk), .errPid(errPid), .errLen(errLen), .errCrc(errCrc),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pktDone === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Token body: 11 field bits LSB first, then inverted CRC5 MSB first
  function automatic logic [79:0] tok_body(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] d;
    logic [4:0]  r;
    logic        fb;
    logic [79:0] res;
    d = {e, a};
    r = 5'h1F;
    res = '0;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ d[i];
      r = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      res[i] = d[i];
    end
    for (int i = 0; i < 5; i++) res[11+i] = ~r[4-i];
    return res;
  endfunction

  function automatic logic [79:0] data_body(input logic [63:0] d);
    logic [15:0] r;
    logic        fb;
    logic [79:0] res;
    r = 16'hFFFF;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      fb = r[15] ^ d[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      res[i] = d[i];
    end
    for (int i = 0; i < 16; i++) res[64+i] = ~r[15-i];
    return res;
  endfunction

  // Called at a negedge; returns at the negedge where pktDone should be high
  task automatic send_pkt(input logic [7:0] p, input logic [79:0] b, input int n);
    pktStart = 1'b1;
    @(negedge clk);
    pktStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bInValid = 1'b1; bIn = p[i];
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      bIn = b[i];
      @(negedge clk);
    end
    bInValid = 1'b0; bIn = 1'b0; pktEnd = 1'b1;
    @(negedge clk);
    pktEnd = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", pktDone, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_type", pktType, 2'b00);
    chk("rst_ok", pktOk, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);

    // OUT token, addr 3A endp A
    send_pkt(8'hE1, tok_body(7'h3A, 4'hA), 16);
    $display("txn token_ok");
    chk("tok_done", pktDone, 1'b1);
    chk("tok_ok", pktOk, 1'b1);
    chk("tok_type", pktType, 2'b01);
    chk("tok_pid", pid, 4'b0001);
    chk("tok_addr", addr, 7'h3A);
    chk("tok_endp", endp, 4'hA);
    @(negedge clk);
    chk("tok_done_1cyc", pktDone, 1'b0);
    chk("tok_ok_hold", pktOk, 1'b1);

    // Same token, CRC bit 2 flipped
    body = tok_body(7'h3A, 4'hA);
    body[13] = ~body[13];
    send_pkt(8'hE1, body, 16);
    $display("txn token_badcrc");
    chk("bcrc_done", pktDone, 1'b1);
    chk("bcrc_ok", pktOk, 1'b0);
    chk("bcrc_errcrc", errCrc, 1'b1);
    chk("bcrc_errlen", errLen, 1'b0);
    @(negedge clk);

    // DATA0 with valid CRC16
    send_pkt(8'hC3, data_body(64'h0123_4567_89AB_CDEF), 80);
    $display("txn data0_ok");
    chk("dat_done", pktDone, 1'b1);
    chk("dat_ok", pktOk, 1'b1);
    chk("dat_type", pktType, 2'b10);
    chk("dat_data", data, 64'h0123_4567_89AB_CDEF);
    chk("dat_errcrc", errCrc, 1'b0);
    @(negedge clk);

    // DATA0 with payload bit 10 dropped: 79 body bits
    body = data_body(64'h0123_4567_89AB_CDEF);
    body2 = {2'b00, body[79:11], body[9:0]};
    send_pkt(8'hC3, body2, 79);
    $display("txn data0_short");
    chk("short_errlen", errLen, 1'b1);
    chk("short_errcrc", errCrc, 1'b0);
    chk("short_ok", pktOk, 1'b0);
    @(negedge clk);

    // ACK, then bad-complement PID
    send_pkt(8'hD2, 80'h0, 0);
    $display("txn ack");
    chk("ack_done", pktDone, 1'b1);
    chk("ack_ok", pktOk, 1'b1);
    chk("ack_type", pktType, 2'b00);
    chk("ack_pid", pid, 4'b0010);
    @(negedge clk);
    send_pkt(8'hD3, 80'h0, 0);
    $display("txn bad_pid");
    chk("bpid_done", pktDone, 1'b1);
    chk("bpid_errpid", errPid, 1'b1);
    chk("bpid_type", pktType, 2'b11);
    chk("bpid_ok", pktOk, 1'b0);
    @(negedge clk);

    // ACK with one surplus body bit
    send_pkt(8'hD2, 80'h1, 1);
    $display("txn ack_long");
    chk("along_errlen", errLen, 1'b1);
    chk("along_errpid", errPid, 1'b0);
    chk("along_ok", pktOk, 1'b0);
    @(negedge clk);

    // pktEnd inside PID: truncated
    pktStart = 1'b1; @(negedge clk); pktStart = 1'b0;
    for (int i = 0; i < 4; i++) begin bInValid = 1'b1; bIn = 1'b1; @(negedge clk); end
    bInValid = 1'b0; pktEnd = 1'b1; @(negedge clk); pktEnd = 1'b0;
    $display("txn pid_trunc");
    chk("ptr_done", pktDone, 1'b1);
    chk("ptr_errlen", errLen, 1'b1);
    chk("ptr_ok", pktOk, 1'b0);
    @(negedge clk);

    // pktEnd in IDLE is ignored
    done_mark = done_cnt;
    pktEnd = 1'b1; @(negedge clk); pktEnd = 1'b0;
    @(negedge clk);
    $display("txn idle_end");
    chk("idle_end_none", done_cnt - done_mark, 0);
    chk("idle_end_busy", busy, 1'b0);

    // Abort a token after 5 body bits with a fresh pktStart, then ACK
    done_mark = done_cnt;
    body = tok_body(7'h11, 4'h2);
    pktStart = 1'b1; @(negedge clk); pktStart = 1'b0;
    for (int i = 0; i < 8; i++) begin bInValid = 1'b1; bIn = ((8'hE1 >> i) & 8'h1) != 0; @(negedge clk); end
    for (int i = 0; i < 5; i++) begin bIn = body[i]; @(negedge clk); end
    bInValid = 1'b0;
    send_pkt(8'hD2, 80'h0, 0);
    @(negedge clk);
    $display("txn abort_restart");
    chk("abort_one_done", done_cnt - done_mark, 1);
    chk("abort_type", pktType, 2'b00);
    chk("abort_ok", pktOk, 1'b1);

    // Reset after 10 token bits
    done_mark = done_cnt;
    body = tok_body(7'h5C, 4'h3);
    pktStart = 1'b1; @(negedge clk); pktStart = 1'b0;
    for (int i = 0; i < 8; i++) begin bInValid = 1'b1; bIn = ((8'hE1 >> i) & 8'h1) != 0; @(negedge clk); end
    for (int i = 0; i < 10; i++) begin bIn = body[i]; @(negedge clk); end
    bInValid = 1'b0;
    rst_b = 1'b0;
    #1;
    $display("txn reset_mid");
    chk("rmid_busy", busy, 1'b0);
    chk("rmid_type", pktType, 2'b00);
    chk("rmid_pid", pid, 4'h0);
    chk("rmid_addr", addr, 7'h00);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rmid_no_done", done_cnt - done_mark, 0);
    chk("rmid_ok", pktOk, 1'b0);
    send_pkt(8'hE1, tok_body(7'h5C, 4'h3), 16);
    $display("txn token_after_reset");
    chk("rtok_done", pktDone, 1'b1);
    chk("rtok_ok", pktOk, 1'b1);
    chk("rtok_addr", addr, 7'h5C);
    chk("rtok_endp", endp, 4'h3);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
